eth_40gb_tx_lane: RTL and testbench

ETH_40GB_TX_LANE -- requirements
Module: eth_40gb_tx_lane

---
 rtl/eth_40gb_tx_lane.sv | 158 +++++++++++++++
 tb/tb_eth_40gb_tx_lane.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_40gb_tx_lane.sv
`default_nettype none
// ============================================================================
// Module   : eth_40gb_tx_lane
// Desc     : 40GBASE-R PCS transmit lane: 64b/66b encode and scramble; with
//            ETH_TX_AM_EN defined, alignment markers carrying BIP3 are inserted.
// Revision : 1.0 - initial release
// ============================================================================
module eth_40gb_tx_lane #(
   parameter int LANE      = 0,
   parameter int AM_PERIOD = 16384
) (
   input  logic        core_clk,
   input  logic        core_reset,
   input  logic [63:0] in_data,
   input  logic [7:0]  in_ctrl,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [65:0] out_block,
   output logic        out_valid
);
   localparam logic [63:0] IDLE_BYTES = {8{8'h07}};
   localparam logic [63:0] IDLE_PAY   = 64'h1E;
   localparam logic [63:0] ERR_PAY    = {{8{7'h1E}}, 8'h1E};
   localparam logic [63:0] TERM_TYPES = 64'hFFE1_D2CC_B4AA_9987;
   localparam logic [57:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF;

   // Out-of-range parameters elaborate nothing extra; legal ones build no hardware here.
   generate
      if (LANE < 0 || LANE > 3 || AM_PERIOD < 4 || AM_PERIOD > 65536) begin : g_param_range
      end
   endgenerate

   logic        take;
   logic [1:0]  sync;
   logic [63:0] pay;
   logic [63:0] scr_pay;
   logic [57:0] scr_next;
   logic [65:0] data_blk;
   logic [57:0] scr_q, scr_d;
   logic [65:0] out_block_q, out_block_d;
   logic        out_valid_q, out_valid_d;

   always_comb begin
      sync = 2'b10;
      pay  = IDLE_PAY;
      if (take) begin
         if (in_ctrl == 8'h00) begin
            sync = 2'b01;
            pay  = in_data;
         end else if (in_ctrl == 8'h01 && in_data[7:0] == 8'hFB) begin
            pay = {in_data[63:8], 8'h78};
         end else if (in_ctrl == 8'hFF && in_data == IDLE_BYTES) begin
            pay = IDLE_PAY;
         end else begin
            pay = ERR_PAY;
            // Tj: control from byte j upward, FD at byte j, idles above it
            for (int j = 0; j < 8; j++) begin
               if (in_ctrl == 8'(8'hFF << j) && in_data[8*j +: 8] == 8'hFD &&
                   (in_data >> (8*j + 8)) == (IDLE_BYTES >> (8*j + 8)))
                  pay = ((in_data & ((64'h1 << (8*j)) - 64'h1)) << 8) |
                        {56'h0, TERM_TYPES[8*j +: 8]};
            end
         end
      end
   end

   always_comb begin
      logic [57:0] st;
      logic        sb;
      st      = scr_q;
      sb      = 1'b0;
      scr_pay = '0;
      for (int i = 0; i < 64; i++) begin
         sb         = pay[i] ^ st[38] ^ st[57];
         scr_pay[i] = sb;
         st         = {st[56:0], sb};
      end
      scr_next = st;
   end

   assign data_blk = {scr_pay, sync};

`ifdef ETH_TX_AM_EN
   localparam logic [15:0] AM_LAST = 16'(AM_PERIOD - 1);
   // {M2, M1, M0} per lane
   localparam logic [23:0] AM_M = (LANE == 0) ? 24'h477690 :
                                  (LANE == 1) ? 24'hE6C4F0 :
                                  (LANE == 2) ? 24'h9B65C5 : 24'h3D79A2;

   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  bip_q, bip_d;
   logic        am_slot;
   logic [65:0] am_blk;

   function automatic logic [7:0] blk_bip(input logic [65:0] b);
      logic [7:0] p;
      p = {3'b000, b[1], b[0], 3'b000};
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 8; k++)
            p[i] = p[i] ^ b[i + 2 + 8*k];
      return p;
   endfunction

   assign am_slot  = (cnt_q == AM_LAST);
   assign in_ready = ~core_reset & ~am_slot;
   assign am_blk   = {~bip_q, ~AM_M, bip_q, AM_M, 2'b10};

   always_comb begin
      cnt_d       = cnt_q + 16'd1;
      bip_d       = bip_q ^ blk_bip(data_blk);
      scr_d       = scr_next;
      out_block_d = data_blk;
      if (am_slot) begin
         cnt_d       = 16'd0;
         bip_d       = blk_bip(am_blk);
         scr_d       = scr_q;
         out_block_d = am_blk;
      end
   end

   always_ff @(posedge core_clk or posedge core_reset) begin
      if (core_reset) begin
         cnt_q <= 16'd0;
         bip_q <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
         bip_q <= bip_d;
      end
   end
`else
   assign in_ready = ~core_reset;

   always_comb begin
      scr_d       = scr_next;
      out_block_d = data_blk;
   end
`endif

   assign take        = in_valid & in_ready;
   assign out_valid_d = 1'b1;

   always_ff @(posedge core_clk or posedge core_reset) begin
      if (core_reset) begin
         scr_q       <= SCR_SEED;
         out_block_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         scr_q       <= scr_d;
         out_block_q <= out_block_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_block = out_block_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_40gb_tx_lane.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_40gb_tx_lane
// Desc     : Self-checking bench for eth_40gb_tx_lane (AM checks with ETH_TX_AM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_40gb_tx_lane;
`ifdef ETH_TX_AM_EN
   localparam int LANE      = 2;
   localparam int AM_PERIOD = 8;
   localparam bit AM_EN     = 1'b1;
   localparam int LONG_RUN  = 200;
`else
   localparam int LANE      = 0;
   localparam int AM_PERIOD = 16384;
   localparam bit AM_EN     = 1'b0;
   localparam int LONG_RUN  = 40000;
`endif
   localparam logic [63:0] IDLE_PAY = 64'h1E;
   localparam logic [63:0] ERR_PAY  = {{8{7'h1E}}, 8'h1E};
   localparam logic [65:0] IDLE_BLK = {IDLE_PAY, 2'b10};
   localparam logic [65:0] ERR_BLK  = {ERR_PAY, 2'b10};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [65:0] out_block;
   logic        out_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   eth_40gb_tx_lane #(.LANE(LANE), .AM_PERIOD(AM_PERIOD)) dut (
      .core_clk  (clk),
      .core_reset(rst),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_block (out_block),
      .out_valid (out_valid)
   );

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Encoding rules stated byte-wise: find the first control byte and classify.
   function automatic logic [65:0] encode(input logic [7:0] c, input logic [63:0] d);
      logic [7:0]  b [8];
      logic [63:0] p;
      int          j;
      bit          ok;
      for (int k = 0; k < 8; k++) b[k] = d[8*k +: 8];
      if (c == 8'h00) return {d, 2'b01};
      if (c == 8'h01 && b[0] == 8'hFB) return {d[63:8], 8'h78, 2'b10};
      if (c == 8'hFF && d == {8{8'h07}}) return IDLE_BLK;
      j = 0;
      while (j < 8 && !c[j]) j++;
      ok = (j < 8);
      if (ok) ok = (b[j] == 8'hFD);
      for (int k = 0; k < 8; k++)
         if (k > j && (!c[k] || b[k] != 8'h07)) ok = 1'b0;
      if (!ok) return ERR_BLK;
      p = '0;
      case (j)
         0: p[7:0] = 8'h87;
         1: p[7:0] = 8'h99;
         2: p[7:0] = 8'hAA;
         3: p[7:0] = 8'hB4;
         4: p[7:0] = 8'hCC;
         5: p[7:0] = 8'hD2;
         6: p[7:0] = 8'hE1;
         default: p[7:0] = 8'hFF;
      endcase
      for (int k = 0; k < j; k++) p[8 + 8*k +: 8] = b[k];
      return {p, 2'b10};
   endfunction

   function automatic logic [7:0] bip_of(input logic [65:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int p = 2; p < 66; p++) r[(p - 2) % 8] = r[(p - 2) % 8] ^ b[p];
      r[3] = r[3] ^ b[0];
      r[4] = r[4] ^ b[1];
      return r;
   endfunction

   function automatic logic [65:0] am_block(input logic [7:0] bip3);
      logic [7:0] m0, m1, m2;
      case (LANE)
         0:       begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; end
         1:       begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; end
         2:       begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; end
         default: begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; end
      endcase
      return {~bip3, ~m2, ~m1, ~m0, bip3, m2, m1, m0, 2'b10};
   endfunction

   // Reference model: next expected block, updated on each rising edge.
   int          mpos = 0;
   logic [7:0]  mbip = 8'h00;
   logic [57:0] mscr = '1;
   logic [65:0] exp_blk = '0;
   logic [65:0] raw;
   logic        exp_ok = 1'b0;
   logic        exp_am = 1'b0;
   logic        msb;

   always @(posedge clk) begin
      if (rst) begin
         mpos   = 0;
         mbip   = 8'h00;
         mscr   = '1;
         exp_ok = 1'b0;
         exp_am = 1'b0;
      end else begin
         exp_am = AM_EN && (mpos == AM_PERIOD - 1);
         if (exp_am) begin
            exp_blk = am_block(mbip);
            mbip    = bip_of(exp_blk);
         end else begin
            raw = in_valid ? encode(in_ctrl, in_data) : IDLE_BLK;
            exp_blk[1:0] = raw[1:0];
            for (int i = 0; i < 64; i++) begin
               msb            = raw[i+2] ^ mscr[38] ^ mscr[57];
               exp_blk[i+2]   = msb;
               mscr           = {mscr[56:0], msb};
            end
            mbip = mbip ^ bip_of(exp_blk);
         end
         mpos   = (mpos + 1) % AM_PERIOD;
         exp_ok = 1'b1;
      end
   end

   // Compare process plus independent descrambler for the literal checks.
   logic [57:0] dscr = '1;
   logic [63:0] last_desc = '0;
   logic        dsb;

   always @(negedge clk) begin
      if (rst) begin
         check("reset_out_block", out_block, 66'h0);
         check("reset_out_valid", out_valid, 1'b0);
         check("reset_in_ready", in_ready, 1'b0);
         dscr = '1;
      end else if (exp_ok) begin
         check("out_valid", out_valid, 1'b1);
         check("out_block", out_block, exp_blk);
         check("in_ready", in_ready, !(AM_EN && mpos == AM_PERIOD - 1));
         if (!exp_am) begin
            for (int i = 0; i < 64; i++) begin
               dsb          = out_block[i+2];
               last_desc[i] = dsb ^ dscr[38] ^ dscr[57];
               dscr         = {dscr[56:0], dsb};
            end
         end
`ifdef ETH_TX_AM_EN
         else begin
            check("am_sync", out_block[1:0], 2'b10);
            check("am_m0", out_block[9:2], 8'hC5);
            check("am_m1", out_block[17:10], 8'h65);
            check("am_m2", out_block[25:18], 8'h9B);
            check("am_nm0", out_block[41:34], 8'h3A);
            check("am_nm1", out_block[49:42], 8'h9A);
            check("am_nm2", out_block[57:50], 8'h64);
            check("am_nbip", out_block[65:58], ~out_block[33:26]);
         end
`endif
      end
   end

   task automatic send(input logic [7:0] c, input logic [63:0] d);
      bit acc;
      acc = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #2;
      end
      in_valid = 1'b0;
      check("send_accepted", acc, 1'b1);
   endtask

   task automatic expect_desc(input string name, input logic [1:0] s, input logic [63:0] p);
      @(negedge clk); #1;
      check({name, "_sync"}, out_block[1:0], s);
      check(name, last_desc, p);
   endtask

   initial begin
      logic [7:0] ctl_tab [5];
      int         t;
      ctl_tab = '{8'h00, 8'hFF, 8'h01, 8'hF8, 8'h0F};
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         @(negedge clk); #1;
         if (!exp_am) begin
            check("idle_sync", out_block[1:0], 2'b10);
            check("idle_desc", last_desc, IDLE_PAY);
         end
      end

      send(8'h00, 64'h0123_4567_89AB_CDEF);
      expect_desc("data", 2'b01, 64'h0123_4567_89AB_CDEF);
      send(8'h01, 64'hDDCC_BBAA_9988_77FB);
      expect_desc("start", 2'b10, 64'hDDCC_BBAA_9988_7778);
      send(8'hF8, 64'h0707_0707_FD33_2211);
      expect_desc("term3", 2'b10, 64'h0000_0000_3322_11B4);
      send(8'hFF, 64'h0707_0707_0707_07FD);
      expect_desc("term0", 2'b10, 64'h0000_0000_0000_0087);
      send(8'h80, 64'hFD66_5544_3322_1100);
      expect_desc("term7", 2'b10, 64'h6655_4433_2211_00FF);
      send(8'hFF, 64'h0707_0707_0707_0707);
      expect_desc("idle_explicit", 2'b10, IDLE_PAY);
      send(8'h0F, 64'h1234_5678_9ABC_DEF0);
      expect_desc("err_ctrl", 2'b10, ERR_PAY);
      send(8'h01, 64'hDDCC_BBAA_9988_77FC);
      expect_desc("err_start", 2'b10, ERR_PAY);
      send(8'hFF, 64'h0707_0007_0707_0707);
      expect_desc("err_idle", 2'b10, ERR_PAY);

      // Reset pulse mid-interval; model restarts counter, BIP and scrambler.
      t = 0;
`ifdef ETH_TX_AM_EN
      @(posedge clk); #2;
      while (mpos != 5 && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      check("reach_counter5", t < 100, 1'b1);
`else
      @(posedge clk); #2;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      send(8'h00, 64'hA5A5_5A5A_0F0F_F0F0);
      expect_desc("post_reset_data", 2'b01, 64'hA5A5_5A5A_0F0F_F0F0);
      repeat (20) @(posedge clk);

      for (int n = 0; n < LONG_RUN; n++) begin
         @(posedge clk); #2;
         in_valid = 1'b1;
         in_ctrl  = ctl_tab[$urandom_range(0, 4)];
         in_data  = {$urandom, $urandom};
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      fails++;
      $display("FAIL watchdog: got no finish, required finish before 2 ms");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
